// File: rtl/rv_pkg.sv
// Shared RV32 core definitions.
// Used by decode, writeback and the register file.
package rv_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = 5'd0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One register file read port.
// x0 masking plus priority write-first bypass.
module regfile_read_port
  import rv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NWR  = 2,
  parameter int AW   = 5
) (
  input  logic [AW-1:0]       addr,
  input  logic [XLEN-1:0]     word,
  input  logic                busy_bit,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  output logic [XLEN-1:0]     data,
  output logic                busy
);

  logic            hit;
  logic [XLEN-1:0] byp;

  // highest-index matching write port supplies the bypass
  always_comb begin
    hit = 1'b0;
    byp = '0;
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w] && wr_addr[w*AW +: AW] == addr) begin
        hit = 1'b1;
        byp = wr_data[w*XLEN +: XLEN];
      end
    end
  end

  // x0 reads zero and is never busy
  always_comb begin
    data = '0;
    busy = 1'b0;
    if (addr != AW'(ZERO_REG)) begin
      data = hit ? byp : word;
      busy = busy_bit & ~hit;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with busy scoreboard.
// Same-cycle writes are bypassed to every read port.
module regfile_scoreboard
  import rv_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = 2,
  parameter  int NWR   = 2,
  localparam int AW    = clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                flush
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [NREGS-1:0] wb_hit;

  // later ports overwrite earlier ones, so the highest index wins
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++)
        regs[r] <= '0;
    end else begin
      for (int w = 0; w < NWR; w++)
        if (wr_en[w] && wr_addr[w*AW +: AW] != AW'(ZERO_REG))
          regs[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
    end
  end

  // which registers see a writeback this cycle
  always_comb begin
    wb_hit = '0;
    for (int w = 0; w < NWR; w++)
      if (wr_en[w])
        wb_hit[wr_addr[w*AW +: AW]] = 1'b1;
  end

  // scoreboard: flush, then new producer, then writeback
  always_comb begin
    busy_nxt = busy;
    for (int r = 1; r < NREGS; r++) begin
      if (flush)
        busy_nxt[r] = 1'b0;
      else if (iss_en && iss_addr == AW'(r))
        busy_nxt[r] = 1'b1;
      else if (wb_hit[r])
        busy_nxt[r] = 1'b0;
    end
    busy_nxt[0] = 1'b0;
  end

  // busy vector register
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rd_addr[p*AW +: AW];

    regfile_read_port #(
      .XLEN (XLEN),
      .NWR  (NWR),
      .AW   (AW)
    ) u_rd (
      .addr     (a),
      .word     (regs[a]),
      .busy_bit (busy[a]),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .data     (rd_data[p*XLEN +: XLEN]),
      .busy     (rd_busy[p])
    );
  end

endmodule
